// File: rtl/trace_pkg.sv
// trace_pkg
//   Shared definitions for the commit trace buffer: the trace state encoding
//   and the widths/layout of one buffered retirement entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_t;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int WADDR_W = 5;
    localparam int WDATA_W = 32;
    localparam int SEQ_W   = 16;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               we;
        logic [WADDR_W-1:0] waddr;
        logic [WDATA_W-1:0] wdata;
        logic [SEQ_W-1:0]   seq;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous FIFO with registered storage and a zero-latency head read.
//   Ports:
//     clk, rst         clock, synchronous active-high reset (pointers/count)
//     push, wdata      write request and data; accepted when not full, or
//                      when full and a pop happens in the same cycle
//     pop              read request; ignored while empty
//     rdata            head entry, forced to zero while empty
//     full, empty      occupancy == DEPTH / occupancy == 0
//     count            occupancy, $clog2(DEPTH)+1 bits
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    // Empty head reads as zero so stale storage never leaks onto the outputs.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf
//   Captures retired instructions into a FIFO for a trace consumer until a
//   halt PC retires or a retirement budget is used up, then drains and
//   reports done.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     retire_*, rf_*           one retirement per cycle when retire_valid
//     out_valid/out_ready      head entry handshake: an entry leaves on a
//                              cycle where out_valid && out_ready; out_*
//                              hold steady while out_valid && !out_ready
//     out_pc..out_seq          head entry fields
//     full                     FIFO holds DEPTH entries
//     overflow                 sticky: at least one retirement was dropped
//     done                     trace finished and fully drained
//     dbg_state                current trace state
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] HALT_PC    = 32'h0000_0048,
    parameter int          MAX_RETIRE = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         retire_valid,
    input  logic [31:0]  retire_pc,
    input  logic [31:0]  retire_instr,
    input  logic         rf_we,
    input  logic [4:0]   rf_waddr,
    input  logic [31:0]  rf_wdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_instr,
    output logic         out_we,
    output logic [4:0]   out_waddr,
    output logic [31:0]  out_wdata,
    output logic [15:0]  out_seq,
    output logic         full,
    output logic         overflow,
    output logic         done,
    output trace_state_t dbg_state
);

    localparam int          CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [31:0] MAX_RETIRE_U = 32'(MAX_RETIRE);

    trace_state_t       state_q, state_d;
    logic [SEQ_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               space;
    logic               drain_empty;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    trace_entry_t       entry_in;
    trace_entry_t       head;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign pop   = !fifo_empty && out_ready;
    assign space = !fifo_full || pop;
    // True when the FIFO is empty now or its last entry leaves this cycle.
    assign drain_empty = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

    always_comb begin
        entry_in       = '0;
        entry_in.pc    = retire_pc;
        entry_in.instr = retire_instr;
        entry_in.we    = rf_we;
        entry_in.waddr = rf_waddr;
        entry_in.wdata = rf_we ? rf_wdata : '0;
        entry_in.seq   = retire_cnt_q;
    end

    always_comb begin
        state_d      = state_q;
        retire_cnt_d = retire_cnt_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (retire_valid) begin
                    if (space) push = 1'b1;
                    else       overflow_d = 1'b1;
                    // Dropped retirements still consume a sequence number so
                    // the consumer sees the gap.
                    if (retire_cnt_q != 16'hFFFF) retire_cnt_d = retire_cnt_q + 16'd1;
                    if ((retire_pc == HALT_PC) || ({16'd0, retire_cnt_d} >= MAX_RETIRE_U))
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            retire_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (entry_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head      = fifo_rdata;
    assign out_valid = !fifo_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_we    = head.we;
    assign out_waddr = head.waddr;
    assign out_wdata = head.wdata;
    assign out_seq   = head.seq;
    assign full      = fifo_full;
    assign overflow  = overflow_q;
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf
//   Directed scenarios plus a random phase for commit_trace_buf, checked
//   cycle by cycle against a queue-based reference model.
module tb_commit_trace_buf;
    import trace_pkg::*;

    localparam int          DEPTH      = 16;
    localparam logic [31:0] HALT_PC    = 32'h0000_0048;
    localparam int          MAX_RETIRE = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         retire_valid;
    logic [31:0]  retire_pc;
    logic [31:0]  retire_instr;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_instr;
    logic         out_we;
    logic [4:0]   out_waddr;
    logic [31:0]  out_wdata;
    logic [15:0]  out_seq;
    logic         full;
    logic         overflow;
    logic         done;
    trace_state_t dbg_state;

    commit_trace_buf #(
        .DEPTH      (DEPTH),
        .HALT_PC    (HALT_PC),
        .MAX_RETIRE (MAX_RETIRE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_instr (retire_instr),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_we       (out_we),
        .out_waddr    (out_waddr),
        .out_wdata    (out_wdata),
        .out_seq      (out_seq),
        .full         (full),
        .overflow     (overflow),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of expected entries plus trace phase.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          seq;
    } exp_entry_t;

    exp_entry_t exp_q[$];
    int         m_cnt;
    bit         m_ovf;
    int         m_phase;   // 0 = RUN, 1 = DRAIN, 2 = DONE
    int         got_seq[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom & 32'hFFFF_FFFC;
        if (p == HALT_PC) p = p + 32'd4;
        return p;
    endfunction

    task automatic model_step(input bit r, input bit rv, input logic [31:0] pc,
                              input logic [31:0] instr, input bit we, input logic [4:0] wa,
                              input logic [31:0] wd, input bit rdy);
        bit         popping;
        bit         space;
        exp_entry_t e;
        if (r) begin
            exp_q.delete();
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_phase = 0;
        end else begin
            popping = (exp_q.size() != 0) && rdy;
            if (m_phase == 0 && rv) begin
                space   = (exp_q.size() < DEPTH) || popping;
                e.pc    = pc;
                e.instr = instr;
                e.we    = we;
                e.waddr = wa;
                e.wdata = we ? wd : 32'd0;
                e.seq   = m_cnt;
                if (popping) void'(exp_q.pop_front());
                if (space) exp_q.push_back(e);
                else       m_ovf = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (pc == HALT_PC || m_cnt >= MAX_RETIRE) m_phase = 1;
            end else begin
                if (popping) void'(exp_q.pop_front());
                if (m_phase == 1 && exp_q.size() == 0) m_phase = 2;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("full", full, exp_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("done", done, m_phase == 2);
        chk("state", dbg_state, m_phase);
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
            chk("out_we", out_we, exp_q[0].we);
            chk("out_waddr", out_waddr, exp_q[0].waddr);
            chk("out_wdata", out_wdata, exp_q[0].wdata);
            chk("out_seq", out_seq, exp_q[0].seq);
        end
    endtask

    // One clock: drive inputs, check registered outputs, advance the model.
    task automatic cycle(input bit r, input bit rv, input logic [31:0] pc,
                         input logic [31:0] instr, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd, input bit rdy);
        rst          = r;
        retire_valid = rv;
        retire_pc    = pc;
        retire_instr = instr;
        rf_we        = we;
        rf_waddr     = wa;
        rf_wdata     = wd;
        out_ready    = rdy;
        check_outputs();
        if (out_valid && rdy && !r) got_seq.push_back(int'(out_seq));
        model_step(r, rv, pc, instr, we, wa, wd, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input bit rdy);
        cycle(1'b0, 1'b1, pc, $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, rand_pc(), $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom, rdy);
    endtask

    // Reset with retire_valid high to show reset wins over a retirement.
    task automatic do_reset();
        cycle(1'b1, 1'b1, rand_pc(), $urandom, 1'b1, 5'd3, $urandom, 1'b1);
        got_seq.delete();
    endtask

    task automatic chk_seq_stream(input string tag, input int n);
        chk({tag, "_count"}, got_seq.size(), n);
        for (int i = 0; i < got_seq.size() && i < n; i++)
            chk($sformatf("%s_seq%0d", tag, i), got_seq[i], i);
    endtask

    initial begin
        rst = 1'b1; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

        // Reset state, including zeroed data fields.
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_we", out_we, 1'b0);
        chk("rst_waddr", out_waddr, 5'd0);
        chk("rst_wdata", out_wdata, 32'd0);
        chk("rst_seq", out_seq, 16'd0);
        do_reset();
        chk("rst_dominates_valid", out_valid, 1'b0);

        // 1: five retirements at PC 0..16, consumer always ready.
        for (int k = 0; k < 5; k++) begin
            retire(32'(k * 4), 1'b1);
            chk("s1_valid_next", out_valid, 1'b1);
            chk("s1_seq_next", out_seq, 16'(k));
        end
        repeat (3) idle(1'b1);
        chk_seq_stream("s1", 5);
        chk("s1_overflow", overflow, 1'b0);

        // 2: consumer stalled, 18 retirements into 16 entries.
        do_reset();
        for (int k = 0; k < 18; k++) begin
            retire(rand_pc(), 1'b0);
            if (k == 15) chk("s2_full_after16", full, 1'b1);
        end
        chk("s2_overflow", overflow, 1'b1);
        repeat (18) idle(1'b1);
        chk_seq_stream("s2", 16);

        // 3: full FIFO, push and pop in the same cycle.
        do_reset();
        for (int k = 0; k < 16; k++) retire(rand_pc(), 1'b0);
        retire(rand_pc(), 1'b1);
        chk("s3_full", full, 1'b1);
        chk("s3_overflow", overflow, 1'b0);
        repeat (18) idle(1'b1);
        chk_seq_stream("s3", 17);

        // 4: halt PC with 3 entries queued.
        do_reset();
        for (int k = 0; k < 3; k++) retire(rand_pc(), 1'b0);
        retire(HALT_PC, 1'b0);
        chk("s4_drain", dbg_state, ST_DRAIN);
        repeat (2) retire(rand_pc(), 1'b0);
        repeat (3) idle(1'b1);
        chk("s4_done_early", done, 1'b0);
        idle(1'b1);
        chk("s4_done", done, 1'b1);
        retire(rand_pc(), 1'b1);
        chk_seq_stream("s4", 4);
        chk("s4_done_held", done, 1'b1);

        // 5: retirement budget.
        do_reset();
        for (int k = 0; k < MAX_RETIRE + 1; k++) retire(rand_pc(), 1'b1);
        repeat (2) idle(1'b1);
        chk_seq_stream("s5", MAX_RETIRE);
        chk("s5_done", done, 1'b1);

        // 6: reset while draining.
        do_reset();
        for (int k = 0; k < 3; k++) retire(rand_pc(), 1'b0);
        retire(HALT_PC, 1'b0);
        chk("s6_in_drain", dbg_state, ST_DRAIN);
        do_reset();
        chk("s6_valid", out_valid, 1'b0);
        chk("s6_done", done, 1'b0);
        chk("s6_state", dbg_state, ST_RUN);
        retire(rand_pc(), 1'b1);
        chk("s6_first_seq", out_seq, 16'd0);
        idle(1'b1);

        // 7: random traffic with occasional halts and stalls.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) != 0)
                retire(($urandom_range(0, 149) == 0) ? HALT_PC : rand_pc(),
                       1'($urandom_range(0, 1)));
            else
                idle(1'($urandom_range(0, 1)));
        end
        repeat (20) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
